// File: rtl/rom_arbiter.sv
// Round-robin arbiter sharing the two read ports of a 1-cycle registered dual-port ROM.
// Up to two grants per cycle; data returns to the granted requesters one cycle later.
module rom_arbiter #(
    parameter int ADD_WIDTH  = 8,
    parameter int DATA_WIDTH = 8,
    parameter int NREQ       = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NREQ-1:0]            req_valid,
    input  logic [NREQ*ADD_WIDTH-1:0]  req_addr,
    output logic [NREQ-1:0]            req_ready,
    output logic [NREQ-1:0]            rsp_valid,
    output logic [NREQ*DATA_WIDTH-1:0] rsp_data,
    output logic [ADD_WIDTH-1:0]       rom_addr,
    output logic [ADD_WIDTH-1:0]       rom_addr2,
    input  logic [DATA_WIDTH-1:0]      rom_dout,
    input  logic [DATA_WIDTH-1:0]      rom_dout2
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    // Handshake: a read of requester i transfers in any cycle where req_valid[i] && req_ready[i];
    // req_ready is combinational from req_valid and rr_ptr only, never from the ROM data.
    logic [PW-1:0]   rr_ptr;
    logic [PW-1:0]   rr_ptr_nxt;
    logic [NREQ-1:0] gnt0;
    logic [NREQ-1:0] gnt1;
    logic [NREQ-1:0] psel;
    logic            g0_found;
    logic            g1_found;
    int              g0;
    int              g1;
    int              idx0;
    int              idx1;

    always_comb begin
        gnt0     = '0;
        gnt1     = '0;
        g0_found = 1'b0;
        g1_found = 1'b0;
        g0       = 0;
        g1       = 0;
        idx0     = 0;
        idx1     = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx0 = (int'(rr_ptr) + k) % NREQ;
            if (!g0_found && req_valid[idx0]) begin
                g0_found   = 1'b1;
                g0         = idx0;
                gnt0[idx0] = 1'b1;
            end
        end
        // Port 1 continues the cyclic search after g0; k starts at 1 so g0 itself is skipped.
        for (int k = 1; k < NREQ; k++) begin
            idx1 = (g0 + k) % NREQ;
            if (g0_found && !g1_found && req_valid[idx1]) begin
                g1_found   = 1'b1;
                g1         = idx1;
                gnt1[idx1] = 1'b1;
            end
        end
    end

    always_comb begin
        rom_addr   = '0;
        rom_addr2  = '0;
        rr_ptr_nxt = rr_ptr;
        if (g0_found) begin
            rom_addr   = req_addr[g0*ADD_WIDTH +: ADD_WIDTH];
            rr_ptr_nxt = PW'((g0 + 1) % NREQ);
        end
        if (g1_found) begin
            rom_addr2  = req_addr[g1*ADD_WIDTH +: ADD_WIDTH];
            rr_ptr_nxt = PW'((g1 + 1) % NREQ);
        end
    end

    assign req_ready = gnt0 | gnt1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr    <= '0;
            rsp_valid <= '0;
            psel      <= '0;
        end else begin
            rr_ptr    <= rr_ptr_nxt;
            rsp_valid <= req_ready;
            psel      <= (psel & ~req_ready) | gnt1;
        end
    end

    // The ROM read stage lines up with rsp_valid, so its outputs are steered straight through.
    for (genvar i = 0; i < NREQ; i++) begin : g_rsp
        assign rsp_data[i*DATA_WIDTH +: DATA_WIDTH] =
            rsp_valid[i] ? (psel[i] ? rom_dout2 : rom_dout) : '0;
    end

endmodule

// File: tb/tb_rom_arbiter.sv
// Directed bench for rom_arbiter (NREQ=4) with a registered dual-port ROM model.
// Expected grants and addresses are hand-derived; expected data comes from the ROM function.
module tb_rom_arbiter;

    localparam int AW   = 8;
    localparam int DW   = 8;
    localparam int NREQ = 4;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ*AW-1:0]   req_addr;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ-1:0]      rsp_valid;
    logic [NREQ*DW-1:0]   rsp_data;
    logic [AW-1:0]        rom_addr;
    logic [AW-1:0]        rom_addr2;
    logic [DW-1:0]        rom_dout = '0;
    logic [DW-1:0]        rom_dout2 = '0;

    int                   n_checks = 0;
    int                   n_errors = 0;
    int                   gcnt[NREQ];
    logic [NREQ*AW-1:0]   a;

    rom_arbiter #(.ADD_WIDTH(AW), .DATA_WIDTH(DW), .NREQ(NREQ)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rom_addr  (rom_addr),
        .rom_addr2 (rom_addr2),
        .rom_dout  (rom_dout),
        .rom_dout2 (rom_dout2)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] rom_f(input logic [AW-1:0] ad);
        return (ad * 8'd3) ^ 8'hA5;
    endfunction

    always_ff @(posedge clk) begin
        rom_dout  <= rom_f(rom_addr);
        rom_dout2 <= rom_f(rom_addr2);
    end

    function automatic logic [NREQ*DW-1:0] exp_rsp(input logic [NREQ-1:0] v,
                                                   input logic [NREQ*AW-1:0] ad);
        logic [NREQ*DW-1:0] r;
        r = '0;
        for (int i = 0; i < NREQ; i++)
            if (v[i]) r[i*DW +: DW] = rom_f(ad[i*AW +: AW]);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One grant cycle: drive, check the combinational grant, then check the response one cycle later.
    task automatic step(input string tag, input logic [NREQ-1:0] v, input logic [NREQ*AW-1:0] ad,
                        input logic [NREQ-1:0] er, input logic [AW-1:0] ea0, input logic [AW-1:0] ea1);
        req_valid = v;
        req_addr  = ad;
        #1;
        chk({tag, " req_ready"}, 32'(req_ready), 32'(er));
        chk({tag, " rom_addr"},  32'(rom_addr),  32'(ea0));
        chk({tag, " rom_addr2"}, 32'(rom_addr2), 32'(ea1));
        for (int i = 0; i < NREQ; i++) gcnt[i] += int'(req_ready[i]);
        @(posedge clk);
        #1;
        chk({tag, " rsp_valid"}, 32'(rsp_valid), 32'(er));
        chk({tag, " rsp_data"},  32'(rsp_data),  32'(exp_rsp(er, ad)));
    endtask

    initial begin
        // Reset with every requester valid
        rst_n     = 1'b0;
        req_valid = 4'hF;
        req_addr  = {8'h40, 8'h30, 8'h20, 8'h10};
        #2;
        chk("reset rsp_valid", 32'(rsp_valid), 32'h0);
        chk("reset rsp_data",  32'(rsp_data),  32'h0);
        chk("reset req_ready", 32'(req_ready), 32'h3);
        chk("reset rom_addr",  32'(rom_addr),  32'h10);
        chk("reset rom_addr2", 32'(rom_addr2), 32'h20);
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("reset rsp_valid held", 32'(rsp_valid), 32'h0);
        chk("reset rsp_data held",  32'(rsp_data),  32'h0);
        rst_n = 1'b1;

        // Full contention from rr_ptr=0: pairs (0,1),(2,3),(0,1),(2,3)
        for (int i = 0; i < NREQ; i++) gcnt[i] = 0;
        for (int c = 0; c < 4; c++) begin
            for (int i = 0; i < NREQ; i++) a[i*AW +: AW] = 8'(c*16 + i + 1);
            if (c % 2 == 0) step($sformatf("contention%0d", c), 4'hF, a, 4'b0011, a[7:0], a[15:8]);
            else            step($sformatf("contention%0d", c), 4'hF, a, 4'b1100, a[23:16], a[31:24]);
        end
        for (int i = 0; i < NREQ; i++) chk($sformatf("grant count %0d", i), 32'(gcnt[i]), 32'd2);

        // Single requester, 3 back-to-back cycles; rr_ptr ends at 3
        for (int c = 0; c < 3; c++)
            step($sformatf("single%0d", c), 4'b0100, {8'h00, 8'h40, 8'h00, 8'h00}, 4'b0100, 8'h40, 8'h00);
        step("idle", 4'b0000, {8'h11, 8'h22, 8'h33, 8'h44}, 4'b0000, 8'h00, 8'h00);

        // Wrap-around from rr_ptr=3, then confirm rr_ptr=1 through the next grant pair
        step("wrap", 4'b1001, {8'h33, 8'h00, 8'h00, 8'h0C}, 4'b1001, 8'h33, 8'h0C);
        step("after wrap", 4'hF, {8'h53, 8'h52, 8'h51, 8'h50}, 4'b0110, 8'h51, 8'h52);
        step("move ptr", 4'b1000, {8'h77, 8'h00, 8'h00, 8'h00}, 4'b1000, 8'h77, 8'h00);

        // Same address on both ports from rr_ptr=0: requester 1 on port 0, 3 on port 1
        step("same addr", 4'b1010, {8'hFF, 8'h00, 8'hFF, 8'h00}, 4'b1010, 8'hFF, 8'hFF);
        chk("psel1", 32'(dut.psel[1]), 32'd0);
        chk("psel3", 32'(dut.psel[3]), 32'd1);
        chk("same addr rsp1", 32'(rsp_data[15:8]), 32'(rom_f(8'hFF)));
        chk("same addr rsp3", 32'(rsp_data[31:24]), 32'(rom_f(8'hFF)));

        // Reset 2 ns after the edge that granted requester 0
        req_valid = 4'b0001;
        req_addr  = {8'h00, 8'h00, 8'h00, 8'h21};
        #1;
        chk("midflight req_ready", 32'(req_ready), 32'h1);
        @(posedge clk);
        #1;
        chk("midflight rsp_valid pre", 32'(rsp_valid), 32'h1);
        chk("midflight rsp_data pre",  32'(rsp_data),  32'(rom_f(8'h21)));
        #1;
        rst_n     = 1'b0;
        req_valid = 4'b0000;
        #1;
        chk("midflight rsp_valid async", 32'(rsp_valid), 32'h0);
        chk("midflight rsp_data async",  32'(rsp_data),  32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk);
            #1;
            chk($sformatf("post reset rsp_valid%0d", c), 32'(rsp_valid), 32'h0);
        end
        req_valid = 4'hF;
        req_addr  = {8'h04, 8'h03, 8'h02, 8'h01};
        #1;
        chk("post reset req_ready", 32'(req_ready), 32'h3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/rom_arbiter.md
# rom_arbiter

Round-robin arbiter that shares the two synchronous read ports of the dual-port sine ROM (`rom`, 1-cycle registered read) among up to NREQ requesters such as waveform channels, delay taps and test readers. Each cycle it grants at most two requests, one per ROM port, and drives the ROM addresses. One cycle later it routes the ROM outputs back to the granted requesters with a per-requester valid strobe. It sits between the signal-generator address counters and the `rom` instance.

## Interface
- ADD_WIDTH, 8, ROM address width; must match the `rom` instance.
- DATA_WIDTH, 8, ROM data width; must match the `rom` instance.
- NREQ, 4, number of requesters; legal range 2..16, need not be a power of two.

- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  NREQ  bit i: requester i presents an address.
- req_addr  in  NREQ*ADD_WIDTH  requester i address in bits [i*ADD_WIDTH +: ADD_WIDTH].
- req_ready  out  NREQ  bit i: combinational grant; transfer occurs when req_valid[i] & req_ready[i].
- rsp_valid  out  NREQ  bit i: registered; rsp_data slice i is valid this cycle.
- rsp_data  out  NREQ*DATA_WIDTH  slice i: read data for requester i; 0 when rsp_valid[i]=0.
- rom_addr  out  ADD_WIDTH  to ROM `addr` (port 0).
- rom_addr2  out  ADD_WIDTH  to ROM `addr2` (port 1).
- rom_dout  in  DATA_WIDTH  from ROM `dout`.
- rom_dout2  in  DATA_WIDTH  from ROM `dout2`.

## Operation
- State:
  - rr_ptr: $clog2(NREQ) bits, range 0..NREQ-1.
  - rsp_valid register.
  - Per-requester port-select register psel[NREQ]: 0 means port 0, 1 means port 1.
- Port-0 grant g0: the first i with req_valid[i]=1, searching cyclically from rr_ptr (rr_ptr, rr_ptr+1, ... mod NREQ).
- Port-1 grant g1: the first valid i, continuing cyclically from g0+1, with i ≠ g0.
- Grant cases:
  - If no request is valid, there are no grants.
  - If exactly one request is valid, only port 0 is granted.
- Addressing and ready:
  - rom_addr = req_addr[g0] when port 0 is granted, else 0.
  - rom_addr2 = req_addr[g1] when port 1 is granted, else 0.
  - req_ready[i] = 1 iff i ∈ {g0, g1}.
  - req_ready never asserts for an invalid requester.
- Pointer update on each edge:
  - Two grants: rr_ptr ← (g1+1) mod NREQ.
  - One grant: rr_ptr ← (g0+1) mod NREQ.
  - No grants: rr_ptr holds.
- Response pipeline:
  - rsp_valid[i] ← req_ready[i].
  - psel[i] ← 1 if i=g1, 0 if i=g0; otherwise psel[i] holds.
- Response data: combinational; rsp_data[i] = rsp_valid[i] ? (psel[i] ? rom_dout2 : rom_dout) : 0.
- Ordering: a requester holding req_valid high is granted at most once per cycle, so back-to-back grants of the same requester give one response per cycle, in order.
- Fairness: with all NREQ requesters continuously valid, each is granted exactly twice every NREQ cycles (even NREQ), and no requester waits more than ceil(NREQ/2) cycles.

## Timing
- Reset (rst_n=0, asynchronous): rr_ptr=0, rsp_valid=0, psel=0.
  - Consequently rsp_data=0.
  - rom_addr, rom_addr2 and req_ready follow the combinational rules above, with rr_ptr=0.
- Reset mid-operation: in-flight responses are dropped. rsp_valid clears immediately on rst_n falling, not at a clock edge.
- Reset release: first grant is evaluated in the first cycle after rst_n rises, from rr_ptr=0.
- Latency: a request granted in cycle t has rsp_valid and rsp_data in cycle t+1. This exactly matches the ROM's one registered read stage.
- Throughput: 2 reads/cycle sustained when ≥2 requesters are valid; 1 read/cycle with one requester.
- Same address on both ports in the same cycle is legal; both responses carry the same data.
- A requester may change req_addr every cycle. Only the address present in the cycle its req_ready is 1 is read.
- No combinational path from rom_dout/rom_dout2 to req_ready or rom_addr.

## Test plan
- Reset values:
  - Stimulus: assert rst_n=0 with all req_valid=1.
  - Required: rsp_valid=0 and rsp_data=0 throughout reset.
  - Then release rst_n. Required: first cycle grants g0=0 and g1=1, and rr_ptr becomes 2.
- Single requester:
  - Stimulus: req_valid=4'b0100, req_addr[2]=0x40 held for 3 cycles.
  - Required: req_ready=4'b0100 each cycle, rom_addr=0x40, rom_addr2=0.
  - Required: rsp_valid[2]=1 for 3 cycles starting one cycle later, with rsp_data[2] = ROM[0x40] from the model ROM.
- Full contention (NREQ=4, all valid):
  - Required grant pairs: (0,1), (2,3), (0,1), ...
  - Required: each requester gets 2 grants per 4 cycles, and every rsp_data matches ROM[addr] one cycle later.
- Wrap-around:
  - Stimulus: rr_ptr=3 (reached via a grant sequence), req_valid=4'b1001.
  - Required: g0=3 on port 0, g1=0 on port 1, and rr_ptr becomes 1.
- Port routing with same address:
  - Stimulus: requesters 1 and 3 both request address 0xFF in the same cycle.
  - Required: rsp_data[1] = rsp_data[3] = ROM[0xFF].
  - Required: psel[1]=0 and psel[3]=1.
- Reset mid-flight:
  - Stimulus: drop rst_n 2 ns after a clock edge that granted requester 0.
  - Required: rsp_valid[0] falls immediately, and no response is issued after reset release for that request.
